// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_latch: pipeline-mode encodings, debug
// snapshot field offsets and the mode decode / stage-enable helpers.
package pipe_pkg;

    localparam logic [1:0] CONT_MODE = 2'b01;
    localparam logic [1:0] STEP_MODE = 2'b11;

    // Snapshot layout: {eof, halted, mode[1:0], valid, data}; offsets are above NB_DATA
    localparam int DBG_EXTRA_W  = 5;
    localparam int DBG_VALID_OFS = 0;
    localparam int DBG_MODE_OFS  = 1;
    localparam int DBG_HALT_OFS  = 3;
    localparam int DBG_EOF_OFS   = 4;

    typedef enum logic [1:0] {
        MODE_FROZEN = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_STEP   = 2'b10
    } mode_e;

    function automatic mode_e decode_mode(input logic [1:0] mode);
        mode_e m;
        case (mode)
            CONT_MODE: m = MODE_CONT;
            STEP_MODE: m = MODE_STEP;
            default:   m = MODE_FROZEN;
        endcase
        return m;
    endfunction

    function automatic logic stage_enable(input mode_e m, input logic step_pulse);
        logic en;
        case (m)
            MODE_CONT: en = 1'b1;
            MODE_STEP: en = step_pulse;
            default:   en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Rising-edge detector for the debug-unit step request: one-cycle pulse per
// low-to-high transition of i_level, so a held request advances only once.
module step_pulse_gen (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level_prev;

    // Previous sample of the step level, taken every cycle regardless of mode
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_level_prev;

endmodule

// File: rtl/pipe_stage_latch.sv
// Single pipeline latch with valid/ready handshake, stall/flush, step control,
// sticky end-of-program halt and accept counter.
// Optional debug snapshot register enabled by PIPE_STAGE_DEBUG_SNAPSHOT_EN.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int NB_DATA = 85,
    parameter int NB_CNT  = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [1:0]                     i_pipeline_mode,
    input  logic                           i_execute_instruct,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [NB_DATA-1:0]             i_data,
    input  logic                           i_eof_flag,
    input  logic                           i_stall,
    input  logic                           i_flush,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [NB_DATA-1:0]             o_data,
    output logic                           o_eof_flag,
    output logic                           o_halted,
    output logic [NB_CNT-1:0]              o_accept_count,
    output logic [NB_DATA+DBG_EXTRA_W-1:0] o_debug_data
);

    logic               r_valid;
    logic [NB_DATA-1:0] r_data;
    logic               r_eof;
    logic               r_halted;
    logic [NB_CNT-1:0]  r_cnt;

    logic               w_step_pulse;
    mode_e              w_mode;
    logic               w_en;
    logic               w_ready;
    logic               w_accept;

    logic               w_valid_nxt;
    logic [NB_DATA-1:0] w_data_nxt;
    logic               w_eof_nxt;
    logic               w_halted_nxt;
    logic [NB_CNT-1:0]  w_cnt_nxt;

    step_pulse_gen u_step_pulse_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_level (i_execute_instruct),
        .o_pulse (w_step_pulse)
    );

    assign w_mode   = decode_mode(i_pipeline_mode);
    assign w_en     = stage_enable(w_mode, w_step_pulse);
    assign w_ready  = ~i_reset & w_en & ~i_stall & ~i_flush & ~r_halted & (~r_valid | i_ready);
    assign w_accept = i_valid & w_ready;

    // Next-state selection: flush beats stall beats load beats drain
    always_comb begin
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_eof_nxt    = r_eof;
        w_halted_nxt = r_halted;
        w_cnt_nxt    = r_cnt;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = {NB_DATA{1'b0}};
            w_eof_nxt   = 1'b0;
        end else if (i_stall) begin
            w_valid_nxt = r_valid;
        end else if (w_accept) begin
            w_valid_nxt  = 1'b1;
            w_data_nxt   = i_data;
            w_eof_nxt    = i_eof_flag;
            w_halted_nxt = r_halted | i_eof_flag;
            w_cnt_nxt    = r_cnt + NB_CNT'(1);
        end else if (r_valid & i_ready & w_en) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // Stage state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_data   <= {NB_DATA{1'b0}};
            r_eof    <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= {NB_CNT{1'b0}};
        end else begin
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            r_eof    <= w_eof_nxt;
            r_halted <= w_halted_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_ready        = w_ready;
    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_eof_flag     = r_eof;
    assign o_halted       = r_halted;
    assign o_accept_count = r_cnt;

`ifdef PIPE_STAGE_DEBUG_SNAPSHOT_EN
    logic [NB_DATA+DBG_EXTRA_W-1:0] w_snapshot;
    logic [NB_DATA+DBG_EXTRA_W-1:0] r_debug_data;

    // Snapshot of the registered stage state; lags the state by one cycle
    always_comb begin
        w_snapshot                                                 = {(NB_DATA+DBG_EXTRA_W){1'b0}};
        w_snapshot[NB_DATA-1:0]                                    = r_data;
        w_snapshot[NB_DATA+DBG_VALID_OFS]                          = r_valid;
        w_snapshot[NB_DATA+DBG_MODE_OFS+1:NB_DATA+DBG_MODE_OFS]    = i_pipeline_mode;
        w_snapshot[NB_DATA+DBG_HALT_OFS]                           = r_halted;
        w_snapshot[NB_DATA+DBG_EOF_OFS]                            = r_eof;
    end

    // Debug snapshot register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_debug_data <= {(NB_DATA+DBG_EXTRA_W){1'b0}};
        end else begin
            r_debug_data <= w_snapshot;
        end
    end

    assign o_debug_data = r_debug_data;
`else
    assign o_debug_data = {(NB_DATA+DBG_EXTRA_W){1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Scoreboard bench for pipe_stage_latch: directed stimulus pushes expected
// words, a negedge monitor pops and compares each word the stage accepts.
module tb_pipe_stage_latch;

    localparam int NB_DATA = 85;
    localparam int NB_CNT  = 4;
    localparam int NB_DBG  = NB_DATA + 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic               exe;
    logic               iv;
    logic               o_ready;
    logic [NB_DATA-1:0] d;
    logic               eof;
    logic               stall;
    logic               flush;
    logic               o_valid;
    logic               rdy;
    logic [NB_DATA-1:0] o_data;
    logic               o_eof;
    logic               o_halted;
    logic [NB_CNT-1:0]  o_cnt;
    logic [NB_DBG-1:0]  o_dbg;

    int errors = 0;
    int checks = 0;
    logic [NB_DATA:0] exp_q[$];
    logic pend = 1'b0;

    pipe_stage_latch #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_pipeline_mode    (mode),
        .i_execute_instruct (exe),
        .i_valid            (iv),
        .o_ready            (o_ready),
        .i_data             (d),
        .i_eof_flag         (eof),
        .i_stall            (stall),
        .i_flush            (flush),
        .o_valid            (o_valid),
        .i_ready            (rdy),
        .o_data             (o_data),
        .o_eof_flag         (o_eof),
        .o_halted           (o_halted),
        .o_accept_count     (o_cnt),
        .o_debug_data       (o_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] flags, input logic [NB_DATA-1:0] data);
`ifdef PIPE_STAGE_DEBUG_SNAPSHOT_EN
        chk(name, 128'(o_dbg), 128'({flags, data}));
`else
        chk(name, 128'(o_dbg), 128'(0));
`endif
    endtask

    // Monitor: a word accepted at the last edge must match the queue head
    always @(negedge clk) begin
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no word", o_data);
            end else begin
                logic [NB_DATA:0] e;
                e = exp_q.pop_front();
                if (o_valid !== 1'b1 || o_data !== e[NB_DATA-1:0] || o_eof !== e[NB_DATA]) begin
                    errors++;
                    $display("FAIL sb_word: got v=%0b eof=%0b d=%0h expected v=1 eof=%0b d=%0h",
                             o_valid, o_eof, o_data, e[NB_DATA], e[NB_DATA-1:0]);
                end
            end
        end
        pend = iv & o_ready;
    end

    initial begin
        rst = 1'b1; mode = 2'b00; exe = 1'b0; iv = 1'b0; d = '0; eof = 1'b0;
        stall = 1'b0; flush = 1'b0; rdy = 1'b0;
        #3;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_data", 128'(o_data), 128'(0));
        chk("rst_halted", 128'(o_halted), 128'(0));
        chk("rst_cnt", 128'(o_cnt), 128'(0));
        chk("rst_dbg", 128'(o_dbg), 128'(0));
        mode = 2'b01; rdy = 1'b1; iv = 1'b1;
        #1 chk("rst_ready_low", 128'(o_ready), 128'(0));
        iv = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1 chk("ready_after_rst", 128'(o_ready), 128'(1));

        // Continuous back-to-back words
        iv = 1'b1; d = 85'h15; exp_q.push_back({1'b0, 85'h15});
        cyc();
        d = 85'h2A; exp_q.push_back({1'b0, 85'h2A});
        chk("cont_data1", 128'(o_data), 128'h15);
        cyc();
        iv = 1'b0;
        chk("cont_data2", 128'(o_data), 128'h2A);
        chk("cont_cnt2", 128'(o_cnt), 128'(2));
        dbg_chk("dbg_cont", 5'b00011, 85'h15);
        cyc();
        chk("drain_valid", 128'(o_valid), 128'(0));
        chk("drain_data_kept", 128'(o_data), 128'h2A);

        // Downstream backpressure
        rdy = 1'b0; iv = 1'b1; d = 85'h3; exp_q.push_back({1'b0, 85'h3});
        cyc();
        chk("bp_ready_low", 128'(o_ready), 128'(0));
        d = 85'h77;
        cyc();
        chk("bp_data_held", 128'(o_data), 128'h3);
        dbg_chk("dbg_held", 5'b00011, 85'h3);
        rdy = 1'b1; exp_q.push_back({1'b0, 85'h77});
        #1 chk("bp_ready_release", 128'(o_ready), 128'(1));
        cyc();
        iv = 1'b0;
        chk("bp_data_new", 128'(o_data), 128'h77);
        cyc();
        chk("bp_cnt", 128'(o_cnt), 128'(4));

        // Stepwise: held request advances once
        mode = 2'b11; iv = 1'b1; d = 85'h55;
        #1 chk("step_idle_ready", 128'(o_ready), 128'(0));
        exe = 1'b1; exp_q.push_back({1'b0, 85'h55});
        #1 chk("step_ready", 128'(o_ready), 128'(1));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("step_held_ready", 128'(o_ready), 128'(0));
        end
        chk("step_cnt", 128'(o_cnt), 128'(5));
        chk("step_valid_held", 128'(o_valid), 128'(1));
        exe = 1'b0; iv = 1'b0;
        cyc();
        exe = 1'b1;
        cyc();
        chk("step_drain", 128'(o_valid), 128'(0));
        mode = 2'b01;
        cyc();
        mode = 2'b11;
        #1 chk("mode_switch_no_edge", 128'(o_ready), 128'(0));
        exe = 1'b0;

        // Flush beats stall
        mode = 2'b01; rdy = 1'b0; iv = 1'b1; d = 85'hAB; exp_q.push_back({1'b0, 85'hAB});
        cyc();
        iv = 1'b0; stall = 1'b1; flush = 1'b1;
        #1 chk("flush_ready", 128'(o_ready), 128'(0));
        cyc();
        chk("flush_valid", 128'(o_valid), 128'(0));
        chk("flush_data", 128'(o_data), 128'(0));
        stall = 1'b0; flush = 1'b0;

        // Stall holds a word that would otherwise drain
        rdy = 1'b1; iv = 1'b1; d = 85'hCD; exp_q.push_back({1'b0, 85'hCD});
        cyc();
        d = 85'hEE; stall = 1'b1;
        #1 chk("stall_ready", 128'(o_ready), 128'(0));
        cyc();
        chk("stall_valid", 128'(o_valid), 128'(1));
        chk("stall_data", 128'(o_data), 128'hCD);
        stall = 1'b0; iv = 1'b0;
        cyc();
        chk("stall_drain", 128'(o_valid), 128'(0));

        // End of program halts the stage
        iv = 1'b1; d = 85'h1EE; eof = 1'b1; exp_q.push_back({1'b1, 85'h1EE});
        cyc();
        chk("halt_set", 128'(o_halted), 128'(1));
        chk("halt_eof", 128'(o_eof), 128'(1));
        eof = 1'b0; d = 85'h99;
        for (int i = 0; i < 10; i++) begin
            #1 chk("halt_ready", 128'(o_ready), 128'(0));
            cyc();
        end
        chk("halt_drained", 128'(o_valid), 128'(0));
        chk("halt_cnt", 128'(o_cnt), 128'(8));
        dbg_chk("dbg_halt", 5'b11010, 85'h1EE);
        rst = 1'b1; iv = 1'b0;
        #1 chk("rst_halt_clr", 128'(o_halted), 128'(0));
        chk("rst_cnt_clr", 128'(o_cnt), 128'(0));
        chk("rst_eof_clr", 128'(o_eof), 128'(0));
        cyc();
        rst = 1'b0;
        #1 chk("ready_after_halt_rst", 128'(o_ready), 128'(1));

        // Counter wrap: 17 accepts on a 4-bit counter
        iv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d = NB_DATA'(256 + i);
            exp_q.push_back({1'b0, NB_DATA'(256 + i)});
            cyc();
        end
        iv = 1'b0;
        chk("cnt_wrap", 128'(o_cnt), 128'(1));
        cyc();

        // Reset mid-operation discards the held word
        rdy = 1'b0; iv = 1'b1; d = 85'h5A; exp_q.push_back({1'b0, 85'h5A});
        cyc();
        iv = 1'b0;
        chk("mid_valid", 128'(o_valid), 128'(1));
        #4 rst = 1'b1;
        #1 chk("mid_rst_valid", 128'(o_valid), 128'(0));
        chk("mid_rst_data", 128'(o_data), 128'(0));
        cyc();
        rst = 1'b0;
        cyc();

        chk("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
